// File: rtl/sorter_n_pipe.sv
// Bitonic sorter for N {first,second} pairs, per-vector ascending/descending order and key choice; latency STAGES cycles, one vector per cycle.
// A stalled output (valid_out & ~ready_out) freezes every stage and drops ready_in; bubbles travel like data.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module sorter_n_pipe #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [2*DATA_WIDTH-1:0]   pairs_in [N],
    input  logic                      desc_in,
    input  logic                      key_sel_in,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [2*DATA_WIDTH-1:0]   pairs_out [N],
    output logic                      busy
);

    localparam int DW     = DATA_WIDTH;
    localparam int PW     = 2 * DW;
    localparam int LOGN   = $clog2(N);
    localparam int STAGES = LOGN * (LOGN + 1) / 2;

    typedef logic [PW-1:0] tuple_pair_t;

    if (N < 2 || N > 64 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("sorter_n_pipe: N must be a power of 2 in 2..64");
    end

    // src[l] feeds comparator layer l; its result is registered into bank l.
    tuple_pair_t       src    [STAGES][N];
    tuple_pair_t       data_d [STAGES][N];
    tuple_pair_t       data_q [STAGES][N];
    logic [STAGES-1:0] vld_src;
    logic [STAGES-1:0] desc_src;
    logic [STAGES-1:0] ksel_src;
    logic [STAGES-1:0] vld_q;
    logic              adv;

    assign valid_out = vld_q[STAGES-1];
    assign adv       = ~valid_out | ready_out;
    assign ready_in  = adv;
    assign busy      = |vld_q;

    for (genvar i = 0; i < N; i++) begin : g_out
        assign pairs_out[i] = data_q[STAGES-1][i];
    end

    for (genvar l = 0; l < STAGES; l++) begin : g_src
        if (l == 0) begin : g_in
            assign vld_src[0]  = valid_in;
            assign desc_src[0] = desc_in;
            assign ksel_src[0] = key_sel_in;
            for (genvar i = 0; i < N; i++) begin : g_pair
                assign src[0][i] = pairs_in[i];
            end
        end else begin : g_reg
            // Sidecars of bank l-1; the last bank's mode bits are never needed.
            logic desc_q;
            logic ksel_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    desc_q <= 1'b0;
                    ksel_q <= 1'b0;
                end else if (adv) begin
                    desc_q <= desc_src[l-1];
                    ksel_q <= ksel_src[l-1];
                end
            end

            assign vld_src[l]  = vld_q[l-1];
            assign desc_src[l] = desc_q;
            assign ksel_src[l] = ksel_q;
            for (genvar i = 0; i < N; i++) begin : g_pair
                assign src[l][i] = data_q[l-1][i];
            end
        end
    end

    // Merge phase p builds sorted runs of 2^p; layer r compares at distance 2^(p-1-r).
    for (genvar p = 1; p <= LOGN; p++) begin : g_merge
        for (genvar r = 0; r < p; r++) begin : g_layer
            localparam int ST = p * (p - 1) / 2 + r;
            localparam int K  = 1 << p;
            localparam int J  = 1 << (p - 1 - r);

            for (genvar i = 0; i < N; i++) begin : g_cmp
                if ((i ^ J) > i) begin : g_ce
                    localparam int L  = i ^ J;
                    localparam bit UP = ((i & K) == 0);

                    tuple_pair_t a;
                    tuple_pair_t b;
                    logic [PW-1:0] ka;
                    logic [PW-1:0] kb;
                    logic          swap;

                    assign a  = src[ST][i];
                    assign b  = src[ST][L];
                    assign ka = ksel_src[ST] ? {a[DW-1:0], a[PW-1:DW]} : a;
                    assign kb = ksel_src[ST] ? {b[DW-1:0], b[PW-1:DW]} : b;
                    // Strict compares: equal keys stay where they are.
                    assign swap = (UP ^ desc_src[ST]) ? (ka > kb) : (ka < kb);

                    assign data_d[ST][i] = swap ? b : a;
                    assign data_d[ST][L] = swap ? a : b;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q  <= '0;
            data_q <= '{default: '{default: '0}};
        end else if (adv) begin
            vld_q  <= vld_src;
            data_q <= data_d;
        end
    end

endmodule

// File: tb/tb_sorter_n_pipe.sv
// Bench for sorter_n_pipe: four instances (N=2,8,16,64) share stimulus, one is selected at a time.
module tb_sorter_n_pipe;

    localparam int DW = 16;
    localparam int PW = 2 * DW;

    typedef logic [PW-1:0] vec_t [64];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic vin, desc, ksel, rout;
    vec_t din;
    int   sel;
    logic vout, rin, bsy;
    vec_t dout;

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0] pi2 [2],  po2 [2];
    logic [PW-1:0] pi8 [8],  po8 [8];
    logic [PW-1:0] pi16[16], po16[16];
    logic [PW-1:0] pi64[64], po64[64];
    logic vi2, ro2, ri2, vo2, b2;
    logic vi8, ro8, ri8, vo8, b8;
    logic vi16, ro16, ri16, vo16, b16;
    logic vi64, ro64, ri64, vo64, b64;

    assign vi2  = vin && (sel == 0);
    assign vi8  = vin && (sel == 1);
    assign vi16 = vin && (sel == 2);
    assign vi64 = vin && (sel == 3);
    assign ro2  = (sel == 0) ? rout : 1'b1;
    assign ro8  = (sel == 1) ? rout : 1'b1;
    assign ro16 = (sel == 2) ? rout : 1'b1;
    assign ro64 = (sel == 3) ? rout : 1'b1;

    always_comb for (int i = 0; i < 2; i++)  pi2[i]  = din[i];
    always_comb for (int i = 0; i < 8; i++)  pi8[i]  = din[i];
    always_comb for (int i = 0; i < 16; i++) pi16[i] = din[i];
    always_comb for (int i = 0; i < 64; i++) pi64[i] = din[i];

    sorter_n_pipe #(.N(2), .DATA_WIDTH(DW)) u_n2 (
        .clock(clk), .reset(rst), .valid_in(vi2), .ready_in(ri2), .pairs_in(pi2),
        .desc_in(desc), .key_sel_in(ksel), .valid_out(vo2), .ready_out(ro2),
        .pairs_out(po2), .busy(b2));
    sorter_n_pipe #(.N(8), .DATA_WIDTH(DW)) u_n8 (
        .clock(clk), .reset(rst), .valid_in(vi8), .ready_in(ri8), .pairs_in(pi8),
        .desc_in(desc), .key_sel_in(ksel), .valid_out(vo8), .ready_out(ro8),
        .pairs_out(po8), .busy(b8));
    sorter_n_pipe #(.N(16), .DATA_WIDTH(DW)) u_n16 (
        .clock(clk), .reset(rst), .valid_in(vi16), .ready_in(ri16), .pairs_in(pi16),
        .desc_in(desc), .key_sel_in(ksel), .valid_out(vo16), .ready_out(ro16),
        .pairs_out(po16), .busy(b16));
    sorter_n_pipe #(.N(64), .DATA_WIDTH(DW)) u_n64 (
        .clock(clk), .reset(rst), .valid_in(vi64), .ready_in(ri64), .pairs_in(pi64),
        .desc_in(desc), .key_sel_in(ksel), .valid_out(vo64), .ready_out(ro64),
        .pairs_out(po64), .busy(b64));

    always_comb begin
        vout = 1'b0;
        rin  = 1'b0;
        bsy  = 1'b0;
        dout = '{default: '0};
        case (sel)
            0: begin vout = vo2;  rin = ri2;  bsy = b2;  for (int i = 0; i < 2; i++)  dout[i] = po2[i];  end
            1: begin vout = vo8;  rin = ri8;  bsy = b8;  for (int i = 0; i < 8; i++)  dout[i] = po8[i];  end
            2: begin vout = vo16; rin = ri16; bsy = b16; for (int i = 0; i < 16; i++) dout[i] = po16[i]; end
            default: begin vout = vo64; rin = ri64; bsy = b64; for (int i = 0; i < 64; i++) dout[i] = po64[i]; end
        endcase
    end

    function automatic int n_of(input int s);
        case (s)
            0: return 2;
            1: return 8;
            2: return 16;
            default: return 64;
        endcase
    endfunction

    // Expected latencies written out from log2(N)*(log2(N)+1)/2.
    function automatic int st_of(input int s);
        case (s)
            0: return 1;
            1: return 6;
            2: return 10;
            default: return 21;
        endcase
    endfunction

    function automatic logic [PW-1:0] key_of(input logic [PW-1:0] x, input logic ks);
        return ks ? {x[DW-1:0], x[PW-1:DW]} : x;
    endfunction

    // Reference: plain exchange sort on the selected key in the requested direction.
    function automatic void model_sort(input int n, input logic d, input logic ks,
                                       input vec_t a, output vec_t r);
        logic [PW-1:0] t;
        r = a;
        for (int i = 0; i < n - 1; i++)
            for (int j = i + 1; j < n; j++)
                if (d ? (key_of(r[j], ks) > key_of(r[i], ks)) : (key_of(r[j], ks) < key_of(r[i], ks))) begin
                    t = r[i]; r[i] = r[j]; r[j] = t;
                end
    endfunction

    task automatic test_reset;
        rst  = 1'b1;
        vin  = 1'b0;
        rout = 1'b0;
        desc = 1'b0;
        ksel = 1'b0;
        din  = '{default: '0};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            int nz;
            sel = s;
            #1;
            nz = 0;
            for (int i = 0; i < n_of(s); i++) if (dout[i] !== '0) nz++;
            checks += 4;
            if (vout !== 1'b0) begin failures++; $display("FAIL reset_valid_out n=%0d got=%b exp=0", n_of(s), vout); end
            if (bsy !== 1'b0)  begin failures++; $display("FAIL reset_busy n=%0d got=%b exp=0", n_of(s), bsy); end
            if (rin !== 1'b1)  begin failures++; $display("FAIL reset_ready_in n=%0d got=%b exp=1", n_of(s), rin); end
            if (nz != 0)       begin failures++; $display("FAIL reset_pairs_out n=%0d nonzero=%0d exp=0", n_of(s), nz); end
        end
    endtask

    task automatic test_directed;
        int f_in[8] = '{7, 3, 9, 1, 5, 1, 8, 2};
        int s_in[8] = '{0, 4, 0, 9, 0, 2, 0, 0};
        int ea_f[8] = '{1, 1, 2, 3, 5, 7, 8, 9};
        int ea_s[8] = '{2, 9, 0, 4, 0, 0, 0, 0};
        int ed_f[8] = '{1, 3, 1, 9, 8, 7, 5, 2};
        int ed_s[8] = '{9, 4, 2, 0, 0, 0, 0, 0};
        sel = 1;
        for (int m = 0; m < 2; m++) begin
            int   vcnt, vcyc, bad;
            vec_t cap;
            @(negedge clk);
            rout = 1'b1;
            vin  = 1'b1;
            desc = (m == 1);
            ksel = (m == 1);
            din  = '{default: '0};
            for (int i = 0; i < 8; i++) din[i] = {DW'(f_in[i]), DW'(s_in[i])};
            vcnt = 0;
            vcyc = -1;
            cap  = '{default: '0};
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                vin = 1'b0;
                #1;
                if (vout === 1'b1) begin
                    vcnt++;
                    if (vcyc < 0) begin vcyc = c; cap = dout; end
                end
            end
            bad = -1;
            for (int i = 0; i < 8; i++) begin
                logic [PW-1:0] e;
                e = (m == 0) ? {DW'(ea_f[i]), DW'(ea_s[i])} : {DW'(ed_f[i]), DW'(ed_s[i])};
                if (cap[i] !== e && bad < 0) bad = i;
            end
            checks += 3;
            if (vcyc != 6) begin failures++; $display("FAIL directed%0d_latency got=%0d exp=6", m, vcyc); end
            if (vcnt != 1) begin failures++; $display("FAIL directed%0d_valid_cycles got=%0d exp=1", m, vcnt); end
            if (bad >= 0)  begin failures++; $display("FAIL directed%0d_data idx=%0d got=%h", m, bad, cap[bad]); end
        end
    endtask

    // Streams nvec vectors through instance s and checks order, data, latency and stall behaviour.
    task automatic test_stream(input string name, input int s, input int nvec, input int mode,
                               input bit gaps, input int stall_len,
                               output int first_out, output int last_out);
        int   n, st, sent, got, cyc, stalls, stall_left, wr, rd, limit;
        bit   have, stall_done, stalling, prev_stall;
        logic cur_d, cur_k;
        vec_t cur, tmp, prev_dout, r;
        vec_t exp_mem [64];
        int   exp_acc [64];
        int   exp_stl [64];
        n = n_of(s);
        st = st_of(s);
        sent = 0; got = 0; cyc = 0; stalls = 0; stall_left = 0; wr = 0; rd = 0;
        have = 0; stall_done = 0; prev_stall = 0;
        cur_d = 0; cur_k = 0;
        cur = '{default: '0};
        prev_dout = '{default: '0};
        first_out = -1;
        last_out = -1;
        sel = s;
        limit = nvec * 4 + st + stall_len + 40;
        while (got < nvec && cyc < limit) begin
            @(negedge clk);
            if (stall_len > 0 && !stall_done && vout === 1'b1) begin
                stall_left = stall_len;
                stall_done = 1;
            end
            if (stall_left > 0) begin rout = 1'b0; stall_left--; end
            else rout = 1'b1;
            if (!have && sent < nvec && (!gaps || $urandom_range(0, 3) != 0)) begin
                logic [PW-1:0] x;
                tmp = '{default: '0};
                x = PW'($urandom);
                for (int i = 0; i < n; i++) begin
                    case (mode)
                        1: tmp[i] = x;
                        3: tmp[i] = {DW'($urandom_range(0, 3)), DW'($urandom_range(0, 3))};
                        default: tmp[i] = PW'($urandom);
                    endcase
                end
                if (mode == 2) model_sort(n, 1'b0, 1'b0, tmp, cur);
                else cur = tmp;
                cur_d = sent[0];
                cur_k = 1'($urandom_range(0, 1));
                have = 1;
            end
            vin  = have;
            din  = cur;
            desc = cur_d;
            ksel = cur_k;
            #1;
            stalling = (vout === 1'b1) && !rout;
            checks++;
            if (rin !== !stalling) begin
                failures++;
                $display("FAIL %s ready_in cyc=%0d got=%b exp=%b", name, cyc, rin, !stalling);
            end
            if (stalling && prev_stall) begin
                int ch;
                ch = 0;
                for (int i = 0; i < n; i++) if (dout[i] !== prev_dout[i]) ch++;
                checks++;
                if (ch != 0) begin failures++; $display("FAIL %s stall_hold cyc=%0d changed=%0d exp=0", name, cyc, ch); end
            end
            if (vout === 1'b1 && rout) begin
                checks++;
                if (rd == wr) begin
                    failures++;
                    $display("FAIL %s spurious_output cyc=%0d got=valid exp=none", name, cyc);
                end else begin
                    int bad, lat, elat;
                    bad = -1;
                    for (int i = 0; i < n; i++) if (dout[i] !== exp_mem[rd][i] && bad < 0) bad = i;
                    if (bad >= 0) begin
                        failures++;
                        $display("FAIL %s data vec=%0d idx=%0d got=%h exp=%h", name, rd, bad, dout[bad], exp_mem[rd][bad]);
                    end
                    lat  = cyc - exp_acc[rd];
                    elat = st + (stalls - exp_stl[rd]);
                    checks++;
                    if (lat != elat) begin failures++; $display("FAIL %s latency vec=%0d got=%0d exp=%0d", name, rd, lat, elat); end
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                    rd++;
                    got++;
                end
            end
            if (vin && rin === 1'b1) begin
                model_sort(n, cur_d, cur_k, cur, r);
                exp_mem[wr] = r;
                exp_acc[wr] = cyc;
                exp_stl[wr] = stalls;
                wr++;
                sent++;
                have = 0;
            end
            if (stalling) stalls++;
            prev_dout  = dout;
            prev_stall = stalling;
            cyc++;
        end
        vin  = 1'b0;
        rout = 1'b1;
        checks++;
        if (got != nvec) begin failures++; $display("FAIL %s delivered got=%0d exp=%0d", name, got, nvec); end
        @(negedge clk);
        #1;
        checks++;
        if (bsy !== 1'b0) begin failures++; $display("FAIL %s drained_busy got=%b exp=0", name, bsy); end
    endtask

    task automatic test_back_to_back;
        int f, l;
        test_stream("b2b", 1, 10, 0, 1'b0, 0, f, l);
        checks += 2;
        if (f != 6)     begin failures++; $display("FAIL b2b_first_out got=%0d exp=6", f); end
        if (l != f + 9) begin failures++; $display("FAIL b2b_last_out got=%0d exp=%0d", l, f + 9); end
    endtask

    task automatic test_backpressure;
        int f, l;
        test_stream("bp", 1, 4, 0, 1'b0, 3, f, l);
        checks += 2;
        if (f != 9)     begin failures++; $display("FAIL bp_first_out got=%0d exp=9", f); end
        if (l != f + 3) begin failures++; $display("FAIL bp_last_out got=%0d exp=%0d", l, f + 3); end
    endtask

    task automatic test_reset_midflight;
        int nz, seen;
        sel  = 1;
        rout = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vin  = 1'b1;
            desc = 1'(c);
            ksel = 1'b0;
            for (int i = 0; i < 8; i++) din[i] = PW'($urandom);
        end
        @(negedge clk);
        vin = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bsy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", bsy); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        nz = 0;
        for (int i = 0; i < 8; i++) if (dout[i] !== '0) nz++;
        checks += 3;
        if (bsy !== 1'b0)  begin failures++; $display("FAIL midrst_busy got=%b exp=0", bsy); end
        if (vout !== 1'b0) begin failures++; $display("FAIL midrst_valid_out got=%b exp=0", vout); end
        if (nz != 0)       begin failures++; $display("FAIL midrst_pairs_out nonzero=%0d exp=0", nz); end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (vout !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL midrst_no_emit got=%0d exp=0", seen); end
    endtask

    task automatic test_sweep;
        int f, l;
        int sizes[3] = '{0, 2, 3};
        for (int k = 0; k < 3; k++) begin
            test_stream("sweep_rand",   sizes[k], 8, 0, 1'b0, 0, f, l);
            test_stream("sweep_equal",  sizes[k], 3, 1, 1'b0, 0, f, l);
            test_stream("sweep_sorted", sizes[k], 3, 2, 1'b0, 0, f, l);
            test_stream("sweep_ties",   sizes[k], 6, 3, 1'b1, 2, f, l);
        end
    endtask

    initial begin
        rst  = 1'b1;
        vin  = 1'b0;
        rout = 1'b1;
        desc = 1'b0;
        ksel = 1'b0;
        sel  = 1;
        din  = '{default: '0};
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
